// File: rtl/pulse_shaping_regs_pkg.sv
// pulse_shaping_regs_pkg: register map, bit positions and FSM states for the pulse shaping CtrlPort block
package pulse_shaping_regs_pkg;

    localparam logic [4:0] OFF_COMPAT      = 5'h00;
    localparam logic [4:0] OFF_CTRL        = 5'h04;
    localparam logic [4:0] OFF_NUM_TAPS    = 5'h08;
    localparam logic [4:0] OFF_COEFF       = 5'h0C;
    localparam logic [4:0] OFF_STATUS      = 5'h10;
    localparam logic [4:0] OFF_COEFF_RESET = 5'h14;

    localparam logic [31:0] COMPAT_VALUE = 32'h0001_0000;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_BYPASS_BIT = 1;
    localparam int STATUS_DONE_BIT = 16;
    localparam int STATUS_BUSY_BIT = 17;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_COEFF_WAIT
    } state_t;

endpackage

// File: rtl/pulse_shaping_ctrlport_regs.sv
// pulse_shaping_ctrlport_regs: CtrlPort register responder with coefficient AXI-Stream
module pulse_shaping_ctrlport_regs
    import pulse_shaping_regs_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR = 20'h00000,
    parameter int          NUM_TAPS  = 41,
    parameter int          COEFF_W   = 16
) (
    input  logic               ctrlport_clk,
    input  logic               ctrlport_rst_n,
    input  logic               s_ctrlport_req_wr,
    input  logic               s_ctrlport_req_rd,
    input  logic [19:0]        s_ctrlport_req_addr,
    input  logic [31:0]        s_ctrlport_req_data,
    output logic               s_ctrlport_resp_ack,
    output logic [31:0]        s_ctrlport_resp_data,
    output logic               ctrl_enable,
    output logic               ctrl_bypass,
    output logic [COEFF_W-1:0] m_coeff_tdata,
    output logic               m_coeff_tlast,
    output logic               m_coeff_tvalid,
    input  logic               m_coeff_tready
);

    localparam logic [15:0] LAST_TAP = 16'(NUM_TAPS - 1);

    state_t      state_q, state_d;
    logic [15:0] tap_cnt;
    logic        load_done;
    logic        hit, wr_hit, rd_hit, coeff_wr, hs;
    logic [4:0]  off;
    logic [31:0] rd_data;
    logic        unused_data;

    assign hit      = s_ctrlport_req_addr[19:5] == BASE_ADDR[19:5];
    assign off      = s_ctrlport_req_addr[4:0];
    assign wr_hit   = s_ctrlport_req_wr && hit;
    assign rd_hit   = s_ctrlport_req_rd && hit && !s_ctrlport_req_wr;
    assign coeff_wr = state_q == ST_IDLE && wr_hit && off == OFF_COEFF;
    assign hs       = m_coeff_tvalid && m_coeff_tready;
    assign unused_data = ^s_ctrlport_req_data;

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_COMPAT:   rd_data = COMPAT_VALUE;
            OFF_NUM_TAPS: rd_data = 32'(NUM_TAPS);
            OFF_CTRL: begin
                rd_data[CTRL_ENABLE_BIT] = ctrl_enable;
                rd_data[CTRL_BYPASS_BIT] = ctrl_bypass;
            end
            OFF_STATUS: begin
                rd_data[15:0]            = tap_cnt;
                rd_data[STATUS_DONE_BIT] = load_done;
                rd_data[STATUS_BUSY_BIT] = state_q == ST_COEFF_WAIT;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (coeff_wr)
            state_d = ST_COEFF_WAIT;
        else if (state_q == ST_COEFF_WAIT && hs)
            state_d = ST_IDLE;
    end

    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            state_q              <= ST_IDLE;
            s_ctrlport_resp_ack  <= 1'b0;
            s_ctrlport_resp_data <= '0;
            ctrl_enable          <= 1'b0;
            ctrl_bypass          <= 1'b0;
            m_coeff_tdata        <= '0;
            m_coeff_tlast        <= 1'b0;
            m_coeff_tvalid       <= 1'b0;
            tap_cnt              <= '0;
            load_done            <= 1'b0;
        end else begin
            state_q              <= state_d;
            s_ctrlport_resp_ack  <= 1'b0;
            s_ctrlport_resp_data <= '0;
            if (state_q == ST_IDLE) begin
                if (wr_hit) begin
                    // COEFF writes are acked only once the core takes the tap
                    s_ctrlport_resp_ack <= off != OFF_COEFF;
                    if (off == OFF_CTRL) begin
                        ctrl_enable <= s_ctrlport_req_data[CTRL_ENABLE_BIT];
                        ctrl_bypass <= s_ctrlport_req_data[CTRL_BYPASS_BIT];
                    end
                    if (off == OFF_COEFF) begin
                        m_coeff_tdata  <= s_ctrlport_req_data[COEFF_W-1:0];
                        m_coeff_tlast  <= tap_cnt == LAST_TAP;
                        m_coeff_tvalid <= 1'b1;
                        if (tap_cnt == '0)
                            load_done <= 1'b0;
                    end
                    if (off == OFF_COEFF_RESET) begin
                        tap_cnt   <= '0;
                        load_done <= 1'b0;
                    end
                end else if (rd_hit) begin
                    s_ctrlport_resp_ack  <= 1'b1;
                    s_ctrlport_resp_data <= rd_data;
                end
            end else if (hs) begin
                m_coeff_tvalid      <= 1'b0;
                s_ctrlport_resp_ack <= 1'b1;
                tap_cnt             <= m_coeff_tlast ? '0 : tap_cnt + 16'd1;
                if (m_coeff_tlast)
                    load_done <= 1'b1;
            end
        end
    end

    a_no_req_in_coeff_wait: assert property (@(posedge ctrlport_clk) disable iff (!ctrlport_rst_n)
        state_q == ST_COEFF_WAIT |-> !(hit && (s_ctrlport_req_wr || s_ctrlport_req_rd)));

endmodule

// File: tb/tb_pulse_shaping_ctrlport_regs.sv
// tb_pulse_shaping_ctrlport_regs: table vectors plus scoreboarded responses for the CtrlPort register block
module tb_pulse_shaping_ctrlport_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_wr = 1'b0, req_rd = 1'b0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        ack;
    logic [31:0] resp;
    logic        en, byp;
    logic [15:0] tdata;
    logic        tlast, tvalid;
    logic        tready = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [4:0]  off;
        logic [31:0] data;
        logic [31:0] resp;
        bit          en;
        bit          byp;
    } vec_t;
    vec_t vecs[14];

    pulse_shaping_ctrlport_regs dut (
        .ctrlport_clk         (clk),
        .ctrlport_rst_n       (rst_n),
        .s_ctrlport_req_wr    (req_wr),
        .s_ctrlport_req_rd    (req_rd),
        .s_ctrlport_req_addr  (req_addr),
        .s_ctrlport_req_data  (req_data),
        .s_ctrlport_resp_ack  (ack),
        .s_ctrlport_resp_data (resp),
        .ctrl_enable          (en),
        .ctrl_bypass          (byp),
        .m_coeff_tdata        (tdata),
        .m_coeff_tlast        (tlast),
        .m_coeff_tvalid       (tvalid),
        .m_coeff_tready       (tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Response scoreboard: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.name, resp, e.data);
                if (e.cyc >= 0) chk({e.name, "_lat"}, cyc, e.cyc);
            end
        end
    end

    task automatic req(input bit wr, input bit rd, input logic [19:0] addr, input logic [31:0] data,
                       input bit push, input string name, input logic [31:0] exp, input int lat);
        @(negedge clk);
        req_wr = wr;
        req_rd = rd;
        req_addr = addr;
        req_data = data;
        if (push) sb.push_back('{name, exp, lat < 0 ? -1 : cyc + lat});
        @(negedge clk);
        req_wr = 1'b0;
        req_rd = 1'b0;
    endtask

    task automatic coeff_fast(input logic [15:0] c, input bit exp_last, input string name);
        req(1'b1, 1'b0, 20'h0000C, {16'hDEAD, c}, 1'b1, name, 32'h0, 2);
        chk({name, "_tvalid"}, tvalid, 1'b1);
        chk({name, "_tdata"}, tdata, c);
        chk({name, "_tlast"}, tlast, exp_last);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit stable, saw_ack;
        vecs[0]  = '{0, 1, 5'h00, 32'h0,         32'h0001_0000, 0, 0};
        vecs[1]  = '{0, 1, 5'h08, 32'h0,         32'd41,        0, 0};
        vecs[2]  = '{1, 0, 5'h04, 32'h3,         32'h0,         1, 1};
        vecs[3]  = '{0, 1, 5'h04, 32'h0,         32'h3,         1, 1};
        vecs[4]  = '{0, 1, 5'h0C, 32'h0,         32'h0,         1, 1};
        vecs[5]  = '{0, 1, 5'h18, 32'h0,         32'h0,         1, 1};
        vecs[6]  = '{1, 0, 5'h1C, 32'hFFFF_FFFF, 32'h0,         1, 1};
        vecs[7]  = '{0, 1, 5'h10, 32'h0,         32'h0,         1, 1};
        vecs[8]  = '{1, 0, 5'h04, 32'h2,         32'h0,         0, 1};
        vecs[9]  = '{0, 1, 5'h04, 32'h0,         32'h2,         0, 1};
        vecs[10] = '{1, 0, 5'h04, 32'hFFFF_FFFC, 32'h0,         0, 0};
        vecs[11] = '{1, 1, 5'h04, 32'h1,         32'h0,         1, 0};
        vecs[12] = '{0, 1, 5'h04, 32'h0,         32'h1,         1, 0};
        vecs[13] = '{1, 0, 5'h04, 32'h3,         32'h0,         1, 1};

        #1;
        chk("rst_ack", ack, 1'b0);
        chk("rst_resp", resp, 32'h0);
        chk("rst_ctrl", {en, byp}, 2'b00);
        chk("rst_tvalid", {tvalid, tlast, tdata}, 18'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            req(vecs[i].wr, vecs[i].rd, {15'h0, vecs[i].off}, vecs[i].data, 1'b1,
                $sformatf("vec%0d", i), vecs[i].resp, 1);
            chk($sformatf("vec%0d_ctrl", i), {en, byp}, {vecs[i].en, vecs[i].byp});
        end

        // Stalled coefficient: tap held, ack only after handshake
        req(1'b1, 1'b0, 20'h0000C, 32'h0000_8001, 1'b1, "stall_coeff", 32'h0, -1);
        chk("stall_tvalid", tvalid, 1'b1);
        stable = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stable &= tvalid && tdata == 16'h8001 && !tlast;
            saw_ack |= ack;
        end
        chk("stall_hold", stable, 1'b1);
        chk("stall_no_ack", saw_ack, 1'b0);
        tready = 1'b1;
        @(negedge clk);
        chk("stall_ack", ack, 1'b1);
        chk("stall_tvalid_drop", tvalid, 1'b0);
        req(1'b0, 1'b1, 20'h00010, 32'h0, 1'b1, "status_one", 32'h1, 1);

        // Full set of 41 taps
        req(1'b1, 1'b0, 20'h00014, 32'h0, 1'b1, "coeff_reset0", 32'h0, 1);
        for (int i = 0; i < 41; i++)
            coeff_fast(16'h0100 + 16'(i), i == 40, $sformatf("tap%0d", i));
        req(1'b0, 1'b1, 20'h00010, 32'h0, 1'b1, "status_done", 32'h0001_0000, 1);
        coeff_fast(16'h0A5A, 1'b0, "tap41");
        req(1'b0, 1'b1, 20'h00010, 32'h0, 1'b1, "status_cleared", 32'h1, 1);
        coeff_fast(16'h0002, 1'b0, "tap42");
        coeff_fast(16'h0003, 1'b0, "tap43");
        req(1'b0, 1'b1, 20'h00010, 32'h0, 1'b1, "status_three", 32'h3, 1);
        req(1'b1, 1'b0, 20'h00014, 32'h1234, 1'b1, "coeff_reset1", 32'h0, 1);
        req(1'b0, 1'b1, 20'h00010, 32'h0, 1'b1, "status_zero", 32'h0, 1);

        // Out-of-window requests are ignored
        req(1'b1, 1'b0, 20'h00024, 32'h0, 1'b0, "", 32'h0, 0);
        saw_ack = ack;
        req(1'b0, 1'b1, 20'h80000, 32'h0, 1'b0, "", 32'h0, 0);
        saw_ack |= ack;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_ack |= ack;
        end
        chk("oow_no_ack", saw_ack, 1'b0);
        chk("oow_ctrl", {en, byp}, 2'b11);

        // Asynchronous reset while waiting for the core
        tready = 1'b0;
        req(1'b1, 1'b0, 20'h0000C, 32'h0000_7777, 1'b1, "lost_coeff", 32'h0, -1);
        chk("pre_rst_tvalid", tvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", {tvalid, tlast, tdata}, 18'h0);
        chk("arst_ctrl", {en, byp, ack}, 3'b000);
        chk("arst_resp", resp, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tready = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            saw_ack |= ack | tvalid;
        end
        chk("post_rst_quiet", saw_ack, 1'b0);
        req(1'b0, 1'b1, 20'h00000, 32'h0, 1'b1, "post_rst_compat", 32'h0001_0000, 1);
        req(1'b0, 1'b1, 20'h00010, 32'h0, 1'b1, "post_rst_status", 32'h0, 1);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pulse_shaping_ctrlport_regs.md
# pulse_shaping_ctrlport_regs

CtrlPort responder for the PulseShapingFilter block, on the client side of the block's NoC shell CtrlPort master. Decodes register reads and writes, holds the filter control bits and reports status. Converts coefficient writes into an AXI-Stream of filter taps, with a `tlast` marker on the final tap of each set. Each write to the coefficient register is acknowledged only after the filter core accepts that tap.

## Interface
- `BASE_ADDR`, default 20'h00000: block window base; only `req_addr[19:5]` is compared.
- `NUM_TAPS`, default 41: taps per coefficient set, range 1..65535.
- `COEFF_W`, default 16: coefficient width, range 1..32.
- `ctrlport_clk`  in  1  sole clock.
- `ctrlport_rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_ctrlport_req_wr`  in  1  write strobe, single cycle.
- `s_ctrlport_req_rd`  in  1  read strobe, single cycle.
- `s_ctrlport_req_addr`  in  20  byte address.
- `s_ctrlport_req_data`  in  32  write data.
- `s_ctrlport_resp_ack`  out  1  response strobe, single cycle.
- `s_ctrlport_resp_data`  out  32  read data, valid while ack is high, otherwise 0.
- `ctrl_enable`  out  1  filter enable.
- `ctrl_bypass`  out  1  filter bypass.
- `m_coeff_tdata`  out  COEFF_W  coefficient.
- `m_coeff_tlast`  out  1  last tap of the set.
- `m_coeff_tvalid`  out  1  coefficient valid.
- `m_coeff_tready`  in  1  core accepts coefficient.

## Operation
- Register map (offset = `req_addr[4:0]`):
  - 0x00 COMPAT: RO, 32'h0001_0000.
  - 0x04 CTRL: RW; bit0 enable, bit1 bypass; other bits read 0.
  - 0x08 NUM_TAPS: RO, zero-extended parameter.
  - 0x0C COEFF: WO; reads return 0.
  - 0x10 STATUS: RO; [15:0] taps accepted in the current set; bit16 load_done; bit17 coeff_busy.
  - 0x14 COEFF_RESET: WO, any data.
  - Other offsets inside the window: writes are ignored and acked; reads return 0 and are acked.
- Requests with `req_addr[19:5] != BASE_ADDR[19:5]` are not acked and change no state.
- If wr and rd are asserted together, the write is serviced and the read is dropped.
- FSM states are IDLE and COEFF_WAIT.
  - IDLE: a write to COEFF loads `m_coeff_tdata <= req_data[COEFF_W-1:0]` and sets `m_coeff_tlast <= (tap_cnt == NUM_TAPS-1)`. It then asserts tvalid and moves to COEFF_WAIT.
  - COEFF_WAIT: on `tvalid && tready`, deassert tvalid, pulse ack the next cycle and return to IDLE.
  - On that handshake, tap_cnt increments. If the handshake carried tlast, tap_cnt wraps to 0 and load_done sets.
- load_done clears on the first COEFF write of a new set (tap_cnt == 0 in IDLE) or on a COEFF_RESET write.
- COEFF_RESET: tap_cnt is set to 0, then the write is acked.
- Requests arriving in COEFF_WAIT are a protocol violation and are ignored. Assertions must flag them.
- Reset values: ack 0, resp_data 0, enable 0, bypass 0, tdata 0, tlast 0, tvalid 0, tap_cnt 0, load_done 0, state IDLE.
- coeff_busy = (state == COEFF_WAIT).

## Timing
- Reads and non-COEFF writes: ack is asserted the cycle after the request; resp_data is registered with it.
- CTRL write updates take effect on the same edge as ack.
- COEFF write, request at cycle t:
  - tvalid is asserted at t+1.
  - With the handshake at cycle h (h ≥ t+1), ack is asserted at h+1.
  - With `tready` held high, ack is at t+2.
- tdata and tlast are stable while tvalid is high, per AXI-Stream rules.
- Asynchronous reset mid-COEFF_WAIT: tvalid drops immediately, no ack is issued, and the tap is lost.
- After reset deassertion, the first request is accepted on the next rising edge.

## Structure
- Package `pulse_shaping_regs_pkg`:
  - register offset localparams;
  - COMPAT value;
  - CTRL and STATUS bit indices;
  - FSM state enum.
- Single flat module; no sub-module. The coefficient output register is inline, with no skid buffer, because ack already throttles the master.

## Test plan
- Reset, then read 0x00 and 0x08 → ack 1 cycle later; data 32'h0001_0000 and 32'd41.
- Write CTRL = 3, then read back → enable = bypass = 1; readback 32'h3; ack 1 cycle after each request.
- With tready low for 5 cycles, write COEFF = 32'h0000_8001 → tdata 16'h8001 held for 5 cycles, no ack; raise tready → ack 1 cycle after the handshake; STATUS[15:0] = 1.
- Write 41 coefficients with tready = 1 → tlast only on the 41st tap; STATUS = 32'h0001_0000 (count wrapped, load_done set); the 42nd write clears load_done.
- Write 3 taps, write COEFF_RESET, then read STATUS → 0. Read offset 0x18 → ack with data 0. Issue a request with addr[19:5] ≠ base → no ack.
- Drop `ctrlport_rst_n` while in COEFF_WAIT → all outputs return to reset values asynchronously; no ack follows release.
